// File: rtl/udp_sweep_checker.sv
// udp_sweep_checker: drives x/y/z through all eight input combinations of a
// 3-input cell, samples f after a settle window, and compares each sample with
// an expected truth table.
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           sweep request, taken in IDLE or DONE; latches expected
//   expected[7:0]   expected f for {x,y,z}=i at bit i
//   f_i             output of the cell under test
//   x_o, y_o, z_o   stimulus to the cell (x is the MSB of the vector index)
//   busy, done      sweep running / results held until the next start
//   pass            done with no mismatch
//   captured[7:0]   sampled f per vector index
//   err_cnt[3:0]    mismatch count
//   first_err_idx   index of the first mismatch, valid with err_valid
// Build option: UDP_SWEEP_ABORT_EN ends the sweep at the first mismatch.
module udp_sweep_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       f_i,
    output logic       x_o,
    output logic       y_o,
    output logic       z_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err_idx,
    output logic       err_valid
);
`ifdef UDP_SWEEP_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] cap_q, cap_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [2:0] first_q, first_d;
    logic       err_valid_q, err_valid_d;
    logic       sample, mism;

    // Every output is a decode of registered state only.
    assign busy          = state_q == RUN;
    assign done          = state_q == DONE;
    assign pass          = done && err_cnt_q == 4'd0;
    assign {x_o, y_o, z_o} = busy ? idx_q : 3'b000;
    assign captured      = cap_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_q;
    assign err_valid     = err_valid_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        cap_d       = cap_q;
        err_cnt_d   = err_cnt_q;
        first_d     = first_q;
        err_valid_d = err_valid_q;
        sample      = state_q == RUN && cnt_q == 4'(SETTLE);
        mism        = f_i != exp_q[idx_q];
        if (state_q != RUN && start) begin
            state_d     = RUN;
            idx_d       = 3'd0;
            cnt_d       = 4'd0;
            exp_d       = expected;
            cap_d       = 8'd0;
            err_cnt_d   = 4'd0;
            err_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 4'd1;
            if (sample) begin
                // f_i still reflects the vector held before this edge.
                cap_d[idx_q] = f_i;
                cnt_d        = 4'd0;
                idx_d        = idx_q + 3'd1;
                if (mism) begin
                    err_cnt_d = err_cnt_q + 4'd1;
                    if (!err_valid_q) begin
                        first_d     = idx_q;
                        err_valid_d = 1'b1;
                    end
                end
                if (idx_q == 3'd7 || (ABORT && mism))
                    state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            exp_q       <= 8'd0;
            cap_q       <= 8'd0;
            err_cnt_q   <= 4'd0;
            first_q     <= 3'd0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            cap_q       <= cap_d;
            err_cnt_q   <= err_cnt_d;
            first_q     <= first_d;
            err_valid_q <= err_valid_d;
        end
    end
endmodule

// File: tb/tb_udp_sweep_checker.sv
// tb_udp_sweep_checker: directed and randomized sweeps of two checker
// instances (SETTLE=2 and SETTLE=1) against a truth-table level model.
module tb_udp_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] exp_in = 8'd0;
    logic [7:0] tab = 8'hE8;
    int checks = 0;
    int failures = 0;

    logic       x2, y2, z2, b2, d2, p2, ev2, x1, y1, z1, b1, d1, p1, ev1;
    logic [7:0] c2, c1;
    logic [3:0] e2, e1;
    logic [2:0] fi2, fi1;
    logic       f2, f1, st2, st1;

    always #5 clk = ~clk;

    // The cell under test is modelled as a lookup of its truth table.
    assign f2  = tab[{x2, y2, z2}];
    assign f1  = tab[{x1, y1, z1}];
    assign st2 = start & ~sel;
    assign st1 = start & sel;

    udp_sweep_checker #(.SETTLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .expected(exp_in), .f_i(f2),
        .x_o(x2), .y_o(y2), .z_o(z2), .busy(b2), .done(d2), .pass(p2),
        .captured(c2), .err_cnt(e2), .first_err_idx(fi2), .err_valid(ev2));

    udp_sweep_checker #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .expected(exp_in), .f_i(f1),
        .x_o(x1), .y_o(y1), .z_o(z1), .busy(b1), .done(d1), .pass(p1),
        .captured(c1), .err_cnt(e1), .first_err_idx(fi1), .err_valid(ev1));

    logic [2:0] o_xyz, o_fi;
    logic       o_busy, o_done, o_pass, o_ev;
    logic [7:0] o_cap;
    logic [3:0] o_err;
    assign o_xyz  = sel ? {x1, y1, z1} : {x2, y2, z2};
    assign o_busy = sel ? b1 : b2;
    assign o_done = sel ? d1 : d2;
    assign o_pass = sel ? p1 : p2;
    assign o_cap  = sel ? c1 : c2;
    assign o_err  = sel ? e1 : e2;
    assign o_fi   = sel ? fi1 : fi2;
    assign o_ev   = sel ? ev1 : ev2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_xyz"}, 32'(o_xyz), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_pass"}, 32'(o_pass), 0);
        chk({tag, "_cap"}, 32'(o_cap), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
        chk({tag, "_fidx"}, 32'(o_fi), 0);
        chk({tag, "_ev"}, 32'(o_ev), 0);
    endtask

    // One sweep: expected results come from walking the truth tables.
    // ign > 0 pulses start at edge A+ign, which must be ignored.
    task automatic sweep(input string tag, input logic s, input logic [7:0] t,
                         input logic [7:0] e, input int ign);
        int hold = s ? 2 : 3;
        int len = 8 * hold;
        int m_err = 0;
        int m_first = 0;
        logic [7:0] m_cap = 8'd0;
        bit aborted = 0;
        for (int i = 0; i < 8 && !aborted; i++) begin
            m_cap[i] = t[i];
            if (t[i] != e[i]) begin
                if (m_err == 0) m_first = i;
                m_err++;
`ifdef UDP_SWEEP_ABORT_EN
                aborted = 1;
                len = (i + 1) * hold;
`endif
            end
        end
        sel = s;
        tab = t;
        exp_in = e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_in = ~e;
        chk({tag, "_a_busy"}, 32'(o_busy), 1);
        chk({tag, "_a_done"}, 32'(o_done), 0);
        chk({tag, "_a_xyz"}, 32'(o_xyz), 0);
        chk({tag, "_a_err"}, 32'(o_err), 0);
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            if (k == ign) start = 1'b0;
            if (k < len) begin
                chk({tag, "_vec"}, 32'(o_xyz), 32'(k / hold));
                chk({tag, "_run_busy"}, 32'(o_busy), 1);
                chk({tag, "_run_done"}, 32'(o_done), 0);
            end
            if (k == ign - 1) start = 1'b1;
        end
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 1);
        chk({tag, "_pass"}, 32'(o_pass), 32'(m_err == 0));
        chk({tag, "_cap"}, 32'(o_cap), 32'(m_cap));
        chk({tag, "_err"}, 32'(o_err), 32'(m_err));
        chk({tag, "_ev"}, 32'(o_ev), 32'(m_err != 0));
        if (m_err != 0) chk({tag, "_fidx"}, 32'(o_fi), 32'(m_first));
        chk({tag, "_xyz"}, 32'(o_xyz), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        #0 chk_zero("rst2");
        sel = 1'b1;
        #0 chk_zero("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        sweep("maj_pass", 1'b0, 8'hE8, 8'hE8, 0);
        sweep("maj_e9", 1'b0, 8'hE8, 8'hE9, 0);
        sweep("maj_17", 1'b0, 8'hE8, 8'h17, 0);
        sweep("maj_00", 1'b0, 8'hE8, 8'h00, 0);
        sweep("ignore", 1'b0, 8'hE8, 8'hE8, 5);
        sel = 1'b0;
        exp_in = 8'hE9;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        sweep("after_rst", 1'b0, 8'hE8, 8'hE8, 0);
        sweep("s1_pass", 1'b1, 8'hE8, 8'hE8, 0);
        sweep("s1_fail", 1'b1, 8'hE8, 8'h68, 0);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] rt, re;
            rt = 8'($urandom);
            re = ($urandom_range(0, 2) == 0) ? rt : 8'($urandom);
            sweep("rand", 1'($urandom_range(0, 1)), rt, re, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
